// File: rtl/herring_bus_pkg.sv
// Shared bus types for the herring 6502 board: address regions,
// region match constants and the PHI1/PHI2 sequencer phases.
package herring_bus_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_ROM,
        REGION_IO
    } region_e;

    typedef enum logic {
        PHI_LOW,
        PHI_HIGH
    } phase_e;

    // Matched against address[15:13] and address[15:12]
    localparam logic [2:0] ROM_MATCH = 3'b111;
    localparam logic [3:0] IO_MATCH  = 4'b1000;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/herring_region_classify.sv
// Combinational address[15:10] to bus region decode; shared with the
// chip-select decoder.
module herring_region_classify
    import herring_bus_pkg::*;
(
    input  logic [5:0] i_address,
    output region_e    o_region
);

    always_comb begin
        o_region = REGION_RAM;
        unique case (1'b1)
            (i_address[5:3] == ROM_MATCH): o_region = REGION_ROM;
            (i_address[5:2] == IO_MATCH):  o_region = REGION_IO;
            default:                       o_region = REGION_RAM;
        endcase
    end

endmodule

// File: rtl/herring_cycle_sequencer.sv
// 6502 PHI2 generator and bus cycle sequencer with RAM write strobe.
// Per-region PHI2 wait states are enabled by HERRING_CLK_STRETCH_EN.
module herring_cycle_sequencer
    import herring_bus_pkg::*;
#(
    parameter int LOW_TICKS  = 7,
    parameter int HIGH_TICKS = 8,
    parameter int ROM_WAIT   = 2,
    parameter int IO_WAIT    = 8
) (
    input  logic       clk_src,
    input  logic       reset_n,
    input  logic [5:0] address,
    input  logic       rw,
    output logic       cpu_clk_in,
    output logic       ram_we_n,
    output logic       cycle_end,
    output logic       stretching
);

    localparam int MAXH = HIGH_TICKS + imax(ROM_WAIT, IO_WAIT);
    localparam int CW   = $clog2(imax(LOW_TICKS, MAXH));

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LOW_LAST = cnt_t'(LOW_TICKS - 1);

    phase_e  r_phase;
    cnt_t    r_cnt;
    cnt_t    r_hlast;
    logic    r_rw;
    region_e r_region;
    logic    r_clk;
    logic    r_we_n;
    logic    r_end;

    phase_e  w_phase_nxt;
    cnt_t    w_cnt_nxt;
    cnt_t    w_hlast;
    logic    w_latch;
    logic    w_end;
    logic    w_we_n_nxt;
    region_e w_region;

    herring_region_classify u_classify (
        .i_address (address),
        .o_region  (w_region)
    );

`ifdef HERRING_CLK_STRETCH_EN
    always_comb begin
        w_hlast = cnt_t'(HIGH_TICKS - 1);
        unique case (w_region)
            REGION_ROM: w_hlast = cnt_t'(HIGH_TICKS + ROM_WAIT - 1);
            REGION_IO:  w_hlast = cnt_t'(HIGH_TICKS + IO_WAIT - 1);
            default:    w_hlast = cnt_t'(HIGH_TICKS - 1);
        endcase
    end
`else
    assign w_hlast = cnt_t'(HIGH_TICKS - 1);
`endif

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_latch     = 1'b0;
        w_end       = 1'b0;
        unique case (r_phase)
            PHI_LOW: begin
                if (r_cnt == LOW_LAST) begin
                    w_phase_nxt = PHI_HIGH;
                    w_cnt_nxt   = '0;
                    w_latch     = 1'b1;
                end
            end
            PHI_HIGH: begin
                if (r_cnt == r_hlast) begin
                    w_phase_nxt = PHI_LOW;
                    w_cnt_nxt   = '0;
                    w_end       = 1'b1;
                end
            end
            default: begin
                w_phase_nxt = PHI_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // First and last high ticks stay high for address setup and hold
    always_comb begin
        w_we_n_nxt = !((w_phase_nxt == PHI_HIGH) &&
                       (w_cnt_nxt != '0) &&
                       (w_cnt_nxt != r_hlast) &&
                       !r_rw &&
                       (r_region == REGION_RAM));
    end

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            r_phase  <= PHI_LOW;
            r_cnt    <= '0;
            r_hlast  <= cnt_t'(HIGH_TICKS - 1);
            r_rw     <= 1'b1;
            r_region <= REGION_RAM;
            r_clk    <= 1'b0;
            r_we_n   <= 1'b1;
            r_end    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_rw     <= rw;
                r_region <= w_region;
                r_hlast  <= w_hlast;
            end
            r_clk  <= (w_phase_nxt == PHI_HIGH);
            r_we_n <= w_we_n_nxt;
            r_end  <= w_end;
        end
    end

`ifdef HERRING_CLK_STRETCH_EN
    logic r_stretch;

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            r_stretch <= 1'b0;
        end else begin
            r_stretch <= (w_phase_nxt == PHI_HIGH) &&
                         (int'(w_cnt_nxt) >= HIGH_TICKS);
        end
    end

    assign stretching = r_stretch;
`else
    assign stretching = 1'b0;
`endif

    assign cpu_clk_in = r_clk;
    assign ram_we_n   = r_we_n;
    assign cycle_end  = r_end;

endmodule

// File: doc/herring_cycle_sequencer.md
# herring_cycle_sequencer

Generates the 6502 PHI2 clock from the 50 MHz source and sequences every bus cycle: fixed PHI1 (low) phase, then a PHI2 (high) phase stretched by per-region wait states for slow devices (ROM, ACIA/VIA I/O page). It also produces a glitch-free, hold-safe RAM write strobe and a one-tick end-of-cycle pulse. It sits between the oscillator, the CPU clock input and the address decoder, and replaces a free-running divider.

## Interface
Parameters:
- LOW_TICKS, 7 — clk_src ticks per PHI1 (low) phase; minimum 2.
- HIGH_TICKS, 8 — base clk_src ticks per PHI2 (high) phase; minimum 3.
- ROM_WAIT, 2 — extra high-phase ticks for 0xE000–0xFFFF.
- IO_WAIT, 8 — extra high-phase ticks for 0x8000–0x8FFF.

Ports:
- clk_src  in  1  50 MHz source clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  6  CPU address bits [15:10].
- rw  in  1  CPU RWB (1 = read, 0 = write).
- cpu_clk_in  out  1  PHI2 to the CPU, registered.
- ram_we_n  out  1  active-low RAM write strobe, registered.
- cycle_end  out  1  one-tick pulse on the tick cpu_clk_in falls.
- stretching  out  1  high while the current high phase exceeds HIGH_TICKS.

## Operation
- Reset: state PHI_LOW, tick counter 0, cpu_clk_in=0, ram_we_n=1, cycle_end=0, stretching=0.
- State PHI_LOW: counter runs 0..LOW_TICKS-1. On the last tick, latch address[15:10] and rw, classify region, load high-phase length H = HIGH_TICKS + wait(region); next state PHI_HIGH, cpu_clk_in←1, counter←0.
- Region: ROM if address[15:13]=3'b111; IO if address[15:12]=4'b1000; otherwise RAM (wait 0).
- State PHI_HIGH: counter runs 0..H-1. On the last tick: next state PHI_LOW, cpu_clk_in←0, cycle_end←1 for that one tick, counter←0.
- stretching = 1 while in PHI_HIGH with counter ≥ HIGH_TICKS.
- ram_we_n: low only in PHI_HIGH, for latched rw=0 and region RAM, from counter 1 through counter H-2; high on counter 0 (address setup) and H-1 (hold before PHI2 fall). ROM/IO writes never assert it.
- Latched address/rw are stable for the whole high phase; bus changes during PHI_HIGH are ignored.
- Counter width: $clog2(max(LOW_TICKS, HIGH_TICKS+max(ROM_WAIT,IO_WAIT))); no wrap possible.

## Timing
- Bus cycle length: LOW_TICKS + H ticks; default RAM 15 (3.33 MHz), ROM 17, IO 23.
- Outputs are registered: each transition appears one clk_src edge after the deciding tick; no combinational paths from inputs to outputs.
- Address/rw sampled exactly once per cycle, on the final PHI_LOW tick.
- Reset asserted mid-cycle (including mid-stretch): all outputs go to reset values immediately (asynchronous); after release, first cycle starts with a full PHI_LOW.
- cycle_end and the cpu_clk_in falling edge are produced in the same clock edge.

## Configuration
- HERRING_CLK_STRETCH_EN defined: wait states applied as above.
- Undefined: H = HIGH_TICKS for every region, stretching tied 0, ROM_WAIT/IO_WAIT ignored; ram_we_n and cycle_end behaviour otherwise unchanged.

## Structure
- Shared package herring_bus_pkg: region enum (REGION_RAM, REGION_ROM, REGION_IO), region address-match constants, sequencer state enum (PHI_LOW, PHI_HIGH).
- One sub-module: herring_region_classify — combinational address[15:10] → region; reusable by the chip-select decoder.

## Test plan
- Reset held, then released with address=6'b000000, rw=1 → outputs at reset values; first cpu_clk_in rise 7 ticks after release; period 15, high 8.
- RAM write, address 0x0200, rw=0 → ram_we_n low exactly 6 ticks (high-phase counter 1–6), high on first and last high ticks; cycle_end single pulse at fall.
- ACIA read, address 0x8000, rw=1 → high phase 16 ticks, stretching high for last 8; ram_we_n stays 1.
- ROM read 0xFFFC then RAM read 0x0000 back-to-back → high phases 10 then 8; address toggled mid-high phase has no effect.
- reset_n pulsed low at high-phase counter 12 of an IO cycle → cpu_clk_in, ram_we_n, stretching return to reset values without waiting for a clock edge.
- Build without HERRING_CLK_STRETCH_EN, IO write 0x8400 → high phase 8 ticks, stretching 0, ram_we_n 1.
